// File: rtl/msdf_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : msdf_pkg
// Description : Radix-2 signed-digit codes, FSM encoding and digit helpers
//               shared by the MSDF online adder.
// Revision    : 1.0 - initial release
// ============================================================================
package msdf_pkg;

    localparam logic [1:0] R2_ZERO    = 2'b00;
    localparam logic [1:0] R2_POS_ONE = 2'b01;
    localparam logic [1:0] R2_NEG_ONE = 2'b11;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FILL  = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_FLUSH = 2'd3;

    function automatic logic [1:0] r2_negate(input logic [1:0] d);
        case (d)
            R2_POS_ONE: r2_negate = R2_NEG_ONE;
            R2_NEG_ONE: r2_negate = R2_POS_ONE;
            default:    r2_negate = R2_ZERO;
        endcase
    endfunction

    // The illegal code 2'b10 decodes to zero.
    function automatic logic signed [2:0] r2_decode(input logic [1:0] d);
        case (d)
            R2_POS_ONE: r2_decode = 3'sd1;
            R2_NEG_ONE: r2_decode = -3'sd1;
            default:    r2_decode = 3'sd0;
        endcase
    endfunction

    function automatic logic [1:0] r2_encode(input logic signed [2:0] v);
        case (v)
            3'b001:  r2_encode = R2_POS_ONE;
            3'b111:  r2_encode = R2_NEG_ONE;
            default: r2_encode = R2_ZERO;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/msdf_r2_lane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : msdf_r2_lane
// Description : One radix-2 MSDF online adder lane with one-digit lookahead.
// Revision    : 1.0 - initial release
// ============================================================================
module msdf_r2_lane
    import msdf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_shift,
    input  logic       i_clear,
    input  logic       i_flush,
    input  logic [1:0] i_x,
    input  logic [1:0] i_y,
    output logic [1:0] o_z
);

    logic signed [2:0] r_s;
    logic signed [2:0] r_w;
    logic [1:0]        r_z;

    logic signed [2:0] w_s;
    logic signed [2:0] w_sp;
    logic signed [2:0] w_wp;
    logic signed [2:0] w_t;
    logic signed [2:0] w_wn;
    logic signed [2:0] w_z;

    always_comb begin
        w_s  = i_flush ? 3'sd0 : (r2_decode(i_x) + r2_decode(i_y));
        // A new word starts from empty history: no previous sum, no residual.
        w_sp = i_clear ? 3'sd0 : r_s;
        w_wp = i_clear ? 3'sd0 : r_w;
        w_t  = 3'sd0;
        w_wn = 3'sd0;
        case (w_sp)
            3'b010: w_t = 3'sd1;
            3'b110: w_t = -3'sd1;
            3'b001: begin
                if (w_s >= 3'sd1) begin
                    w_t  = 3'sd1;
                    w_wn = -3'sd1;
                end else begin
                    w_wn = 3'sd1;
                end
            end
            3'b111: begin
                if (w_s <= -3'sd1) begin
                    w_t  = -3'sd1;
                    w_wn = 3'sd1;
                end else begin
                    w_wn = -3'sd1;
                end
            end
            default: ;
        endcase
        w_z = w_wp + w_t;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s <= 3'sd0;
            r_w <= 3'sd0;
            r_z <= R2_ZERO;
        end else if (i_shift) begin
            r_s <= w_s;
            r_w <= w_wn;
            r_z <= r2_encode(w_z);
        end
    end

    assign o_z = r_z;

endmodule
`default_nettype wire

// File: rtl/msdf_online_adder_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : msdf_online_adder_mc
// Description : C-lane radix-2 MSDF online adder, N digits per word, online
//               delay 2. Define MSDF_SUB_EN to add the per-word sub_i input.
// Revision    : 1.0 - initial release
// ============================================================================
module msdf_online_adder_mc
    import msdf_pkg::*;
#(
    parameter int N = 8,
    parameter int C = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic           in_start,
    output logic           in_ready,
    input  logic [2*C-1:0] x_i,
    input  logic [2*C-1:0] y_i,
`ifdef MSDF_SUB_EN
    input  logic           sub_i,
`endif
    output logic           out_valid,
    output logic           out_first,
    output logic           out_last,
    output logic [2*C-1:0] z_o
);

    localparam int              c_CW   = $clog2(N + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_flush_ph;

    logic            w_accept;
    logic            w_restart;
    logic            w_shift;
    logic            w_flush;
    logic            w_neg;
    logic [c_CW-1:0] w_next_cnt;

    assign in_ready   = (r_state != c_ST_FLUSH);
    assign w_accept   = in_valid && in_ready;
    assign w_restart  = w_accept && in_start;
    assign w_flush    = (r_state == c_ST_FLUSH);
    // Slices without in_start are dropped while idle.
    assign w_shift    = (w_accept && (r_state != c_ST_IDLE || in_start)) || w_flush;
    assign w_next_cnt = r_cnt + c_ONE;

`ifdef MSDF_SUB_EN
    logic r_sub;
    assign w_neg = in_start ? sub_i : r_sub;
    always_ff @(posedge clk) begin
        if (rst)
            r_sub <= 1'b0;
        else if (w_restart)
            r_sub <= sub_i;
    end
`else
    assign w_neg = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_flush_ph <= 1'b0;
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            case (r_state)
                c_ST_FLUSH: begin
                    out_valid <= 1'b1;
                    if (r_flush_ph) begin
                        out_last <= 1'b1;
                        r_state  <= c_ST_IDLE;
                    end else begin
                        r_flush_ph <= 1'b1;
                    end
                end
                default: begin
                    // A start in FILL/RUN abandons the word in flight.
                    if (w_restart) begin
                        r_cnt   <= c_ONE;
                        r_state <= c_ST_FILL;
                    end else if (w_accept && r_state != c_ST_IDLE) begin
                        out_valid  <= 1'b1;
                        out_first  <= (r_state == c_ST_FILL);
                        r_cnt      <= w_next_cnt;
                        r_flush_ph <= 1'b0;
                        r_state    <= (w_next_cnt == c_LAST) ? c_ST_FLUSH : c_ST_RUN;
                    end
                end
            endcase
        end
    end

    for (genvar k = 0; k < C; k++) begin : g_lane
        logic [1:0] w_y_eff;
        assign w_y_eff = w_neg ? r2_negate(y_i[2*k+:2]) : y_i[2*k+:2];

        msdf_r2_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_shift (w_shift),
            .i_clear (w_restart),
            .i_flush (w_flush),
            .i_x     (x_i[2*k+:2]),
            .i_y     (w_y_eff),
            .o_z     (z_o[2*k+:2])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_msdf_online_adder_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_msdf_online_adder_mc
// Description : Self-checking bench for msdf_online_adder_mc (N=8, C=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msdf_online_adder_mc;

    localparam int N = 8;
    localparam int C = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_start = 1'b0;
    logic           in_ready;
    logic [2*C-1:0] x_i = '0;
    logic [2*C-1:0] y_i = '0;
`ifdef MSDF_SUB_EN
    logic           sub_i = 1'b0;
`endif
    logic           out_valid;
    logic           out_first;
    logic           out_last;
    logic [2*C-1:0] z_o;

    always #5 clk = ~clk;

    msdf_online_adder_mc #(.N(N), .C(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_start  (in_start),
        .in_ready  (in_ready),
        .x_i       (x_i),
        .y_i       (y_i),
`ifdef MSDF_SUB_EN
        .sub_i     (sub_i),
`endif
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last),
        .z_o       (z_o)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rdy_low = 0;
    int n_last = 0;
    int cap_z0[$];
    int cap_z1[$];
    bit cap_f[$];
    bit cap_l[$];
    int cap_c[$];

    logic [1:0] cx[2][1:N];
    logic [1:0] cy[2][1:N];
    int exp_z[2][0:N];
    int exp_val[2];
    bit sub_w = 1'b0;
    int known_z[0:N] = '{1, -1, 0, 1, 0, 0, -1, 1, -1};
    int known_x[1:N] = '{0, 1, 0, -1, 1, 1, 0, -1};
    int known_y[1:N] = '{1, 0, -1, 0, 1, -1, -1, 0};

    function automatic int dec(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b11) return -1;
        return 0;
    endfunction

    function automatic logic [1:0] enc(input int v);
        if (v > 0) return 2'b01;
        if (v < 0) return 2'b11;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (out_valid) begin
                cap_z0.push_back(dec(z_o[1:0]));
                cap_z1.push_back(dec(z_o[3:2]));
                cap_f.push_back(out_first);
                cap_l.push_back(out_last);
                cap_c.push_back(cyc);
                if (out_last) n_last++;
            end
            if (!in_ready) rdy_low++;
        end
    end

    task automatic clear_caps();
        cap_z0.delete(); cap_z1.delete(); cap_f.delete(); cap_l.delete(); cap_c.delete();
        rdy_low = 0;
        n_last = 0;
    endtask

    // Reference: apply the transfer/residual rules over the whole word, plus its exact value.
    task automatic build_exp();
        int s[1:N+2];
        int t[1:N+1];
        int w[1:N+1];
        for (int k = 0; k < 2; k++) begin
            exp_val[k] = 0;
            for (int j = 1; j <= N; j++) begin
                s[j] = dec(cx[k][j]) + (sub_w ? -dec(cy[k][j]) : dec(cy[k][j]));
                exp_val[k] += s[j] * (1 << (N - j));
            end
            s[N+1] = 0;
            s[N+2] = 0;
            for (int j = 1; j <= N + 1; j++) begin
                t[j] = 0; w[j] = 0;
                if (s[j] == 2)       t[j] = 1;
                else if (s[j] == -2) t[j] = -1;
                else if (s[j] == 1) begin
                    if (s[j+1] >= 1) begin t[j] = 1; w[j] = -1; end
                    else w[j] = 1;
                end else if (s[j] == -1) begin
                    if (s[j+1] <= -1) begin t[j] = -1; w[j] = 1; end
                    else w[j] = -1;
                end
            end
            exp_z[k][0] = t[1];
            for (int j = 1; j <= N; j++) exp_z[k][j] = w[j] + t[j+1];
        end
    endtask

    task automatic rand_codes(input bit any_code);
        for (int k = 0; k < 2; k++)
            for (int j = 1; j <= N; j++) begin
                cx[k][j] = any_code ? 2'($urandom_range(0, 3)) : enc($urandom_range(0, 2) - 1);
                cy[k][j] = any_code ? 2'($urandom_range(0, 3)) : enc($urandom_range(0, 2) - 1);
            end
    endtask

    // Present one slice and hold it until an edge with in_ready high takes it.
    task automatic drive_slice(input bit st, input int j);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_start = st;
        x_i = {cx[1][j], cx[0][j]};
        y_i = {cy[1][j], cy[0][j]};
`ifdef MSDF_SUB_EN
        sub_i = sub_w;
`endif
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end
    endtask

    task automatic send_word(input int upto, input int stall_at, input int stall_len);
        for (int j = 1; j <= upto; j++) begin
            drive_slice(j == 1, j);
            if (j == stall_at) begin
                in_valid = 1'b0;
                repeat (stall_len) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic wait_last(input int want);
        in_valid = 1'b0;
        in_start = 1'b0;
        for (int i = 0; i < 40 && n_last < want; i++) begin @(posedge clk); #1; end
        repeat (2) begin @(posedge clk); #1; end
        vectors++;
        if (n_last !== want) begin
            miscompares++;
            $display("FAIL out_last_count: got %0d required %0d", n_last, want);
        end
    endtask

    task automatic set_known();
        for (int j = 1; j <= N; j++) begin
            cx[0][j] = enc(known_x[j]);
            cy[0][j] = enc(known_y[j]);
            cx[1][j] = enc($urandom_range(0, 2) - 1);
            cy[1][j] = enc($urandom_range(0, 2) - 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors += 5;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        if (out_first !== 1'b0) begin miscompares++; $display("FAIL reset_out_first: got %b required 0", out_first); end
        if (out_last !== 1'b0)  begin miscompares++; $display("FAIL reset_out_last: got %b required 0", out_last); end
        if (z_o !== '0)         begin miscompares++; $display("FAIL reset_z_o: got %h required 0", z_o); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_known(input int stall_len);
        int v;
        set_known();
        build_exp();
        clear_caps();
        // Slices without in_start while idle must vanish.
        in_valid = 1'b1; in_start = 1'b0; x_i = 4'b0101; y_i = 4'b0101;
        repeat (2) begin @(posedge clk); #1; end
        send_word(N, (stall_len > 0) ? 4 : 0, stall_len);
        wait_last(1);
        vectors++;
        if (cap_z0.size() !== N + 1) begin
            miscompares++; $display("FAIL known_count: got %0d digits required %0d", cap_z0.size(), N + 1);
        end
        v = 0;
        for (int i = 0; i <= N; i++) begin
            int g0 = (i < cap_z0.size()) ? cap_z0[i] : 99;
            int g1 = (i < cap_z1.size()) ? cap_z1[i] : 99;
            bit gf = (i < cap_f.size()) ? cap_f[i] : 1'bx;
            bit gl = (i < cap_l.size()) ? cap_l[i] : 1'bx;
            v += g0 * (1 << (N - i));
            vectors += 4;
            if (g0 !== known_z[i]) begin miscompares++; $display("FAIL known_z0[%0d]: got %0d required %0d", i, g0, known_z[i]); end
            if (g1 !== exp_z[1][i]) begin miscompares++; $display("FAIL known_z1[%0d]: got %0d required %0d", i, g1, exp_z[1][i]); end
            if (gf !== (i == 0)) begin miscompares++; $display("FAIL known_first[%0d]: got %b required %b", i, gf, i == 0); end
            if (gl !== (i == N)) begin miscompares++; $display("FAIL known_last[%0d]: got %b required %b", i, gl, i == N); end
        end
        vectors += 3;
        if (v !== 157) begin miscompares++; $display("FAIL known_value: got %0d required 157", v); end
        if (rdy_low !== 2) begin miscompares++; $display("FAIL known_ready_low: got %0d cycles required 2", rdy_low); end
        if (cap_c.size() == N + 1) begin
            int gap = cap_c[3] - cap_c[2];
            int span = cap_c[N] - cap_c[0];
            if (gap !== stall_len + 1 || span !== N + stall_len) begin
                miscompares++;
                $display("FAIL known_timing: gap %0d span %0d required %0d %0d", gap, span, stall_len + 1, N + stall_len);
            end
        end else begin
            miscompares++; $display("FAIL known_timing: got %0d digits required %0d", cap_c.size(), N + 1);
        end
    endtask

    task automatic test_max();
        for (int j = 1; j <= N; j++) begin
            cx[0][j] = 2'b01; cy[0][j] = 2'b01;
            cx[1][j] = 2'b11; cy[1][j] = 2'b11;
        end
        clear_caps();
        send_word(N, 0, 0);
        wait_last(1);
        for (int i = 0; i <= N; i++) begin
            int g0 = (i < cap_z0.size()) ? cap_z0[i] : 99;
            int g1 = (i < cap_z1.size()) ? cap_z1[i] : 99;
            int e = (i < N) ? 1 : 0;
            vectors += 2;
            if (g0 !== e)  begin miscompares++; $display("FAIL max_z0[%0d]: got %0d required %0d", i, g0, e); end
            if (g1 !== -e) begin miscompares++; $display("FAIL max_z1[%0d]: got %0d required %0d", i, g1, -e); end
        end
    endtask

    task automatic test_abort();
        int ez0[3];
        int ez1[3];
        rand_codes(1'b0);
        build_exp();
        for (int i = 0; i < 3; i++) begin ez0[i] = exp_z[0][i]; ez1[i] = exp_z[1][i]; end
        clear_caps();
        send_word(4, 0, 0);
        for (int k = 0; k < 2; k++)
            for (int j = 1; j <= N; j++) begin cx[k][j] = 2'b00; cy[k][j] = 2'b00; end
        send_word(N, 0, 0);
        wait_last(1);
        vectors++;
        if (cap_z0.size() !== N + 4) begin
            miscompares++; $display("FAIL abort_count: got %0d digits required %0d", cap_z0.size(), N + 4);
        end
        for (int i = 0; i < N + 4; i++) begin
            int g0 = (i < cap_z0.size()) ? cap_z0[i] : 99;
            int g1 = (i < cap_z1.size()) ? cap_z1[i] : 99;
            bit gf = (i < cap_f.size()) ? cap_f[i] : 1'bx;
            bit gl = (i < cap_l.size()) ? cap_l[i] : 1'bx;
            int e0 = (i < 3) ? ez0[i] : 0;
            int e1 = (i < 3) ? ez1[i] : 0;
            vectors += 3;
            if (g0 !== e0 || g1 !== e1) begin
                miscompares++; $display("FAIL abort_z[%0d]: got %0d/%0d required %0d/%0d", i, g0, g1, e0, e1);
            end
            if (gf !== (i == 0 || i == 3)) begin miscompares++; $display("FAIL abort_first[%0d]: got %b", i, gf); end
            if (gl !== (i == N + 3)) begin miscompares++; $display("FAIL abort_last[%0d]: got %b", i, gl); end
        end
    endtask

    task automatic test_back_to_back(input int words, input bit any_code);
        int eq0[$];
        int eq1[$];
        int vq[$];
        clear_caps();
        for (int w = 0; w < words; w++) begin
            rand_codes(any_code);
            build_exp();
            for (int i = 0; i <= N; i++) begin eq0.push_back(exp_z[0][i]); eq1.push_back(exp_z[1][i]); end
            vq.push_back(exp_val[0]);
            vq.push_back(exp_val[1]);
            send_word(N, $urandom_range(0, N), $urandom_range(1, 3));
        end
        wait_last(words);
        vectors++;
        if (cap_z0.size() !== eq0.size()) begin
            miscompares++; $display("FAIL b2b_count: got %0d digits required %0d", cap_z0.size(), eq0.size());
        end
        for (int i = 0; i < eq0.size(); i++) begin
            int g0 = (i < cap_z0.size()) ? cap_z0[i] : 99;
            int g1 = (i < cap_z1.size()) ? cap_z1[i] : 99;
            vectors++;
            if (g0 !== eq0[i] || g1 !== eq1[i]) begin
                miscompares++; $display("FAIL b2b_z[%0d]: got %0d/%0d required %0d/%0d", i, g0, g1, eq0[i], eq1[i]);
            end
        end
        for (int w = 0; w < words && cap_z0.size() == eq0.size(); w++) begin
            int v0 = 0;
            int v1 = 0;
            for (int i = 0; i <= N; i++) begin
                v0 += cap_z0[w*(N+1)+i] * (1 << (N - i));
                v1 += cap_z1[w*(N+1)+i] * (1 << (N - i));
            end
            vectors++;
            if (v0 !== vq[2*w] || v1 !== vq[2*w+1]) begin
                miscompares++; $display("FAIL b2b_value[%0d]: got %0d/%0d required %0d/%0d", w, v0, v1, vq[2*w], vq[2*w+1]);
            end
        end
    endtask

`ifdef MSDF_SUB_EN
    task automatic test_sub();
        rand_codes(1'b0);
        for (int k = 0; k < 2; k++)
            for (int j = 1; j <= N; j++) cy[k][j] = cx[k][j];
        sub_w = 1'b1;
        clear_caps();
        send_word(N, 0, 0);
        wait_last(1);
        sub_w = 1'b0;
        for (int i = 0; i <= N; i++) begin
            int g0 = (i < cap_z0.size()) ? cap_z0[i] : 99;
            int g1 = (i < cap_z1.size()) ? cap_z1[i] : 99;
            vectors++;
            if (g0 !== 0 || g1 !== 0) begin miscompares++; $display("FAIL sub_z[%0d]: got %0d/%0d required 0/0", i, g0, g1); end
        end
    endtask
`endif

    task automatic test_reset_mid();
        rand_codes(1'b0);
        clear_caps();
        send_word(6, 0, 0);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors += 5;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
        if (out_first !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_first: got %b required 0", out_first); end
        if (out_last !== 1'b0)  begin miscompares++; $display("FAIL rstmid_out_last: got %b required 0", out_last); end
        if (z_o !== '0)         begin miscompares++; $display("FAIL rstmid_z_o: got %h required 0", z_o); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL rstmid_in_ready: got %b required 1", in_ready); end
        repeat (4) begin @(posedge clk); #1; end
        vectors++;
        if (n_last !== 0) begin miscompares++; $display("FAIL rstmid_no_last: got %0d required 0", n_last); end
        test_back_to_back(1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_known(0);
        test_max();
        test_known(3);
        test_abort();
        test_back_to_back(6, 1'b0);
        test_back_to_back(3, 1'b1);
`ifdef MSDF_SUB_EN
        test_sub();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msdf_online_adder_mc.md
# msdf_online_adder_mc

Parametrised multi-channel radix-2 MSDF online adder: C independent lanes of signed-digit operands, N digits per word, framed by a valid/ready handshake with word-start and word-end markers. It succeeds the single-lane fixed-length serial-serial adder. It feeds downstream online multipliers and accumulators, and emits N+1 result digits per word with online delay 2 and automatic zero-padded flush.

## Interface
- N, 8, digits per input word (≥2)
- C, 1, parallel lanes sharing one handshake
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input digit slice valid
- in_start  in  1  slice is digit 1 of a new word
- in_ready  out  1  block accepts a slice this cycle
- x_i  in  2C  lane k digit at bits [2k+1:2k]
- y_i  in  2C  same layout as x_i
- sub_i  in  1  subtract for this word (only with MSDF_SUB_EN)
- out_valid  out  1  z_o holds a result digit slice
- out_first  out  1  slice is z_0
- out_last  out  1  slice is z_N
- z_o  out  2C  result digits, same layout as x_i

## Operation
- Digit code: 00=0, 01=+1, 11=−1. 10 is illegal and is read as 0.
- Input digit j has weight 2^−j, for j=1..N. Output z_0 has weight 2^0, and z_j has weight 2^−j. Result value equals x+y exactly.
- Per lane: s_j = x_j + y_j, range −2..2.
- Transfer/residual (t_j, w_j), using lookahead s_{j+1}:
  - s=±2 → (±1, 0); s=0 → (0, 0)
  - s=+1 → (1, −1) if s_{j+1} ≥ 1, else (0, +1)
  - s=−1 → (−1, +1) if s_{j+1} ≤ −1, else (0, −1)
- Outputs: z_0 = t_1; z_j = w_j + t_{j+1}, which always lies in {−1, 0, 1}. Padding s_{N+1} = s_{N+2} = 0.
- FSM states: IDLE, FILL, RUN, FLUSH.
  - IDLE → FILL on accepted in_start.
  - FILL → RUN on acceptance of digit 2, which emits z_0.
  - RUN → FLUSH after digit N is accepted.
  - FLUSH lasts 2 cycles, then → IDLE.
- Digit counter runs 1..N. Counter width is clog2(N+1).
- In IDLE, slices without in_start are dropped.
- Accepted in_start in FILL or RUN aborts the current word with no out_last. The slice becomes digit 1 of a new word.
- in_start is ignored in FLUSH, because in_ready=0.
- Stall: in_valid low in FILL or RUN holds all state, and out_valid goes low next cycle.

## Timing
- Reset values: out_valid=0, out_first=0, out_last=0, z_o=0, in_ready=1. State is IDLE and all lookahead registers are 0.
- Accept occurs on a clock edge where in_valid && in_ready.
- Latency: z_{j−2} is registered and presented the cycle after digit j is accepted. Online delay is 2.
- FLUSH: in_ready=0 for 2 cycles, which produce z_{N−1} and then z_N (out_last=1).
- Throughput: N+2 cycles per word with no stalls. in_ready is 1 again on the cycle out_last is shown.
- rst mid-word discards the word immediately. No out_last is produced.
- All lanes run in lockstep. Lanes are independent in arithmetic only.

## Configuration
- MSDF_SUB_EN defined:
  - sub_i port exists and is sampled with in_start.
  - When sub_i=1, y digits of every lane are negated (01↔11) for the whole word.
- MSDF_SUB_EN undefined: no sub_i port, addition only.

## Structure
- Shared package msdf_pkg holds:
  - digit codes R2_ZERO, R2_POS_ONE, R2_NEG_ONE
  - FSM state encoding
  - a digit-negate function
- Sub-module msdf_r2_lane: one per channel, generate-instantiated. It holds the s/t/w lookahead registers and a shift/enable input.
- The top module holds the FSM, counter, handshake and framing flags.

## Test plan
- N=8, C=1, no stalls. Stimulus: x = 0,+1,0,−1,+1,+1,0,−1 and y = +1,0,−1,0,+1,−1,−1,0. Required z = +1,−1,0,+1,0,0,−1,+1,−1 (value 157/256). out_first on z_0, out_last on z_8, in_ready low for 2 cycles.
- Maximum operands, x=y=all +1: z = +1 ×8, then 0 (value 2−2^−7). Repeat on C=2 with lane 1 = negated operands: lane 1 = −1 ×8, then 0.
- Same vectors as the first case with in_valid low for 3 cycles after digit 4: identical z sequence, out_valid gaps aligned to the stall, no extra digits.
- in_start asserted at digit 5, then a full word of zeros: no out_last for the aborted word, followed by 9 zero digits framed with out_first and out_last.
- MSDF_SUB_EN with sub_i=1 and x=y: all 9 z digits are 0. Illegal code 10 on x reads as 0.
- rst pulsed at digit 6: next cycle all outputs are at reset values, in_ready=1, and a following word produces correct results.
